// File: rtl/sync_fifo_in.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo_in : write-side pointer/flag controller of a split synchronous FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
module sync_fifo_in #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 14,
  parameter int DROP_CNT_WIDTH     = 8
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      fifo_write_en_h_i,
  input  logic [DATA_WIDTH-1:0]     fifo_write_data_i,
  output logic                      fifo_full_h_o,
  output logic                      fifo_almost_full_h_o,
  output logic [ADDR_WIDTH:0]       fifo_level_o,
  output logic                      fifo_overflow_h_o,
  input  logic                      fifo_overflow_clr_h_i,
  output logic [DROP_CNT_WIDTH-1:0] fifo_drop_count_o,
  input  logic [ADDR_WIDTH:0]       read_addr_i,
  output logic [ADDR_WIDTH:0]       write_addr_o,
  output logic                      mem_write_en_o,
  output logic [ADDR_WIDTH-1:0]     mem_write_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_write_data_o
);

  localparam int                      PTR_W       = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]        C_DEPTH     = PTR_W'(2 ** ADDR_WIDTH);
  localparam logic [PTR_W-1:0]        C_AF_THRESH = PTR_W'(ALMOST_FULL_THRESH);
  localparam logic [PTR_W-1:0]        C_PTR_ONE   = PTR_W'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] C_CNT_MAX = {DROP_CNT_WIDTH{1'b1}};
  localparam logic [DROP_CNT_WIDTH-1:0] C_CNT_ONE = DROP_CNT_WIDTH'(1);

  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic [PTR_W-1:0] w_level;
  logic             w_full;
  logic             w_accept;
  logic             w_drop;

  // Extra pointer MSB distinguishes full from empty; modular difference is the level.
  assign w_level  = wr_ptr_q - read_addr_i;
  assign w_full   = (w_level == C_DEPTH);
  assign w_accept = fifo_write_en_h_i & ~w_full;
  assign w_drop   = fifo_write_en_h_i &  w_full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (w_accept) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    // A drop in the same cycle as a clear wins, so the count restarts at one.
    if (w_drop) begin
      overflow_d = 1'b1;
      if (fifo_overflow_clr_h_i) begin
        drop_cnt_d = C_CNT_ONE;
      end else if (drop_cnt_q != C_CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + C_CNT_ONE;
      end
    end else if (fifo_overflow_clr_h_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fifo_full_h_o        = w_full;
  assign fifo_almost_full_h_o = (w_level >= C_AF_THRESH);
  assign fifo_level_o         = w_level;
  assign fifo_overflow_h_o    = overflow_q;
  assign fifo_drop_count_o    = drop_cnt_q;
  assign write_addr_o         = wr_ptr_q;
  assign mem_write_en_o       = w_accept;
  assign mem_write_addr_o     = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_write_data_o     = fifo_write_data_i;

endmodule
`default_nettype wire

// File: doc/sync_fifo_in.md
Name: sync_fifo_in

Overview:
- Write-side pointer/flag controller of the split synchronous FIFO. It is the producer counterpart of the FIFO read-side controller.
- Owns the write pointer, drives the shared dual-port memory's write port, and exports the write pointer to the read side. It consumes the read side's pointer to compute full, almost-full and fill level.
- Adds overflow detection: a sticky flag plus a saturating drop counter.
- Both FIFO halves run on the same clock.

Parameters:
- DATA_WIDTH, 16, width of one FIFO word.
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- ALMOST_FULL_THRESH, 14, level at or above which almost-full asserts; legal range 1..DEPTH.
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- resetn_i  input  1  reset; one clock, asynchronous, active-low.
- fifo_write_en_h_i  input  1  producer write request.
- fifo_write_data_i  input  DATA_WIDTH  producer write data.
- fifo_full_h_o  output  1  FIFO full; combinational from pointers.
- fifo_almost_full_h_o  output  1  level >= ALMOST_FULL_THRESH; combinational.
- fifo_level_o  output  ADDR_WIDTH+1  current fill level 0..DEPTH; combinational.
- fifo_overflow_h_o  output  1  sticky: at least one write was dropped.
- fifo_overflow_clr_h_i  input  1  clears the sticky flag and the drop counter.
- fifo_drop_count_o  output  DROP_CNT_WIDTH  number of dropped writes; saturating.
- read_addr_i  input  ADDR_WIDTH+1  read pointer from the read-side controller.
- write_addr_o  output  ADDR_WIDTH+1  write pointer to the read-side controller.
- mem_write_en_o  output  1  memory write strobe.
- mem_write_addr_o  output  ADDR_WIDTH  memory write address = wr_ptr[ADDR_WIDTH-1:0].
- mem_write_data_o  output  DATA_WIDTH  memory write data = fifo_write_data_i.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, fifo_overflow_h_o=0, fifo_drop_count_o=0.
- Comb outputs after reset, with read side also in reset: full=0, almost_full=0, level=0, mem_write_en_o=0 unless a write is requested.
- Reset asserted mid-operation: pointer and error state zero immediately; stored data is abandoned. Both halves must share resetn_i.
- Pointer arithmetic:
  - level = (wr_ptr - read_addr_i) mod 2**(ADDR_WIDTH+1).
  - full = low bits equal AND MSBs differ, i.e. level == DEPTH.
  - empty (read side) = pointers identical.
- Accepted write (fifo_write_en_h_i=1 and full=0):
  - mem_write_en_o=1 in the same cycle.
  - Memory captures data at mem_write_addr_o on that rising edge; wr_ptr increments by 1 on the same edge.
  - Read side sees non-empty from the next cycle, data already valid. Write-to-readable latency is 1 cycle.
- Wrap-around: wr_ptr wraps from 2**(ADDR_WIDTH+1)-1 to 0. The MSB toggles every DEPTH writes, and memory addresses wrap modulo DEPTH.
- Dropped write (fifo_write_en_h_i=1 and full=1):
  - mem_write_en_o=0 and wr_ptr unchanged.
  - fifo_overflow_h_o set on the next edge.
  - fifo_drop_count_o increments, saturating at 2**DROP_CNT_WIDTH-1.
- Write and read in the same cycle while full: the write is still dropped, because full is evaluated on current pointers.
- Write and read in the same cycle while not full: both proceed and the level is unchanged next cycle.
- fifo_overflow_clr_h_i=1: next edge clears the flag and the counter to 0. If a drop occurs in the same cycle, the set wins: flag=1, count=1.
- Writes when not full never touch the overflow state.
- No internal state machine beyond pointer and error registers. Outputs carry no X after reset.

Test Plan:
- Reset, then 16 back-to-back writes (data 0x0000..0x000F), no reads:
  - level counts 1..16.
  - almost_full rises after the 14th write's edge.
  - full rises after the 16th.
  - write_addr_o=0x10, mem addresses 0..15.
- Full FIFO, one extra write 0xDEAD:
  - mem_write_en_o=0, write_addr_o stays 0x10.
  - overflow=1, drop_count=1.
  - a further 300 drops -> count saturates at 255.
- Wrap: interleave 40 writes with reads that keep level at 1..3.
  - write_addr_o passes 0x1F -> 0x00.
  - full never asserts.
  - read side returns data in order with no loss.
- Full FIFO, write+read in the same cycle -> write dropped, level becomes 15. Level 15, write+read in the same cycle -> write accepted, level stays 15.
- overflow_clr together with a dropped write -> flag=1, count=1. overflow_clr alone -> flag=0, count=0 next cycle.
- Assert resetn_i asynchronously mid-burst at level 9 -> write_addr_o=0, overflow=0, count=0 immediately. After release with the read side also reset -> level=0, full=0.
